// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// No logic; latency and backpressure are defined by the modules that import it.
package uart_loader_pkg;

  typedef enum logic [1:0] {COLLECT, WRITE, DONE} loader_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam logic [31:0] TERMINATOR_WORD = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD  = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling; byte_valid/rx_frame_err pulse 1 cycle
// after the stop-bit sample. No backpressure: a byte not consumed on its pulse is lost.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       rx_frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state, state_nxt;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          half_hit, bit_hit;

  assign half_hit  = (cnt == HALF_LAST);
  assign bit_hit   = (cnt == BIT_LAST);
  assign byte_data = shift;

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_s2) state_nxt = RX_START;
      RX_START: if (half_hit) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (bit_hit) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_valid   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= uart_rx;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      state        <= state_nxt;
      byte_valid   <= 1'b0;
      rx_frame_err <= 1'b0;
      // Timer restarts on every state change and at each data-bit boundary.
      if (state != state_nxt || (state == RX_DATA && bit_hit)) begin
        cnt <= '0;
      end else if (state != RX_IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (state == RX_DATA && bit_hit) begin
        shift   <= {rx_s2, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && bit_hit) begin
        if (rx_s2) byte_valid   <= 1'b1;
        else       rx_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: UART bytes -> LE words -> SRAM port 0 from address 0; write strobe 1 cycle after 4th byte.
// No backpressure (SRAM accepts every strobe). UART_LOADER_TIMEOUT_EN adds a partial-word idle timeout.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 87,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int TIMEOUT_CYCLES = 16 * CLKS_PER_BIT * 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  if (CLKS_PER_BIT < 4 || DATA_WIDTH != 32 || NUM_WMASKS != DATA_WIDTH / 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_prog_loader: unsupported parameterisation");
  end

  logic          byte_valid, rx_frame_err;
  logic [7:0]    byte_data;
  loader_state_e state, state_nxt;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [ADDR_WIDTH:0] addr_cnt;
  logic [31:0]   word_full;
  logic          last_byte, take_byte, do_write, set_err, clr_idx, timeout_hit;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .rx_frame_err(rx_frame_err)
  );

  assign word_full  = {byte_data, word_buf};
  assign last_byte  = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign word_count = addr_cnt;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || byte_valid || byte_idx == 2'd0 || state != COLLECT) to_cnt <= '0;
    else                                                           to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    take_byte = 1'b0;
    do_write  = 1'b0;
    set_err   = 1'b0;
    clr_idx   = 1'b0;
    case (state)
      COLLECT: begin
        if (byte_valid) begin
          if (last_byte) begin
            clr_idx = 1'b1;
            if (word_full == TERMINATOR_WORD) begin
              state_nxt = DONE;
            end else if (addr_cnt[ADDR_WIDTH]) begin
              // SRAM already full: refuse rather than wrap onto word 0.
              set_err   = 1'b1;
              state_nxt = DONE;
            end else begin
              do_write  = 1'b1;
              state_nxt = WRITE;
            end
          end else begin
            take_byte = 1'b1;
          end
        end else if (rx_frame_err || timeout_hit) begin
          set_err = 1'b1;
          clr_idx = 1'b1;
        end
      end
      WRITE:   state_nxt = COLLECT;
      DONE:    state_nxt = DONE;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      byte_idx  <= '0;
      word_buf  <= '0;
      addr_cnt  <= '0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      if (set_err) load_err <= 1'b1;
      if (clr_idx) begin
        byte_idx <= '0;
      end else if (take_byte) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= byte_data;
          2'd1:    word_buf[15:8]  <= byte_data;
          2'd2:    word_buf[23:16] <= byte_data;
          default: ;
        endcase
      end
      if (do_write) begin
        csb0   <= 1'b0;
        web0   <= 1'b0;
        wmask0 <= '1;
        addr0  <= addr_cnt[ADDR_WIDTH-1:0];
        din0   <= word_full;
      end
      if (state == WRITE) addr_cnt <= addr_cnt + 1'b1;
      if (state_nxt == DONE) begin
        cpu_rst   <= 1'b0;
        load_done <= 1'b1;
      end
    end
  end

endmodule
